mips32_prog_loader: RTL and testbench
=====================================

// Module: mips32_prog_loader
// PURPOSE
//   Self-checking program loader and result checker for the pipelined MIPS32 core.
//   Streams a program/data image into core memory from word 0, releases the core, and waits for HALT or timeout.
//   Then streams {addr, expected} check pairs, reads memory, and reports pass/fail.
//   Replaces hand-written hierarchical memory preloads with a reusable, parametrised sequencer.
// PARAMETERS
//   DATA_W   32    memory word width
//   ADDR_W   10    memory address width (depth 2**ADDR_W words)
//   CYC_W    16    run-cycle counter width
//   TIMEOUT  1000  max RUN cycles before abort; 0 = no timeout
//   ERR_W    8     mismatch counter width (saturating)
// PORTS
//   clk1        in   1       single clock, rising edge
//   rst         in   1       synchronous, active-high reset
//   start       in   1       pulse: begin sequence (accepted only in IDLE or DONE)
//   ld_valid    in   1       load beat valid
//   ld_ready    out  1       load beat ready
//   ld_data     in   DATA_W  image word
//   ld_last     in   1       final image beat
//   chk_valid   in   1       check beat valid
//   chk_ready   out  1       check beat ready
//   chk_addr    in   ADDR_W  address to check
//   chk_exp     in   DATA_W  expected word
//   chk_last    in   1       final check beat
//   mem_we      out  1       memory write strobe
//   mem_re      out  1       memory read strobe; rdata valid exactly 1 cycle later
//   mem_addr    out  ADDR_W  memory address
//   mem_wdata   out  DATA_W  memory write data
//   mem_rdata   in   DATA_W  memory read data
//   core_run    out  1       high = core fetches from PC 0; low = core held
//   core_halted in   1       core executed HLT
//   busy/done/pass/timeout/ld_ovf  out 1 each  status flags
//   err_cnt     out  ERR_W   mismatch count
//   cyc_cnt     out  CYC_W   cycles spent in RUN
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; ld_ptr, cyc_cnt, and err_cnt cleared. Reset mid-sequence aborts immediately.
//   FSM: IDLE -start-> LOAD -ld_last accepted-> RUN -halt|timeout-> CHK_REQ <-> CHK_WAIT -> DONE -start-> LOAD.
//   start in DONE clears all flags and counters. start in any other non-IDLE state is ignored.
//   LOAD: ld_ready=1. Each beat (valid&ready) sets mem_we=1, mem_addr=ld_ptr, mem_wdata=ld_data in the same cycle; ld_ptr+1.
//     Beat with ld_ptr at 2**ADDR_W: write suppressed, ld_ovf=1 (sticky); beats still drained until ld_last.
//   RUN: core_run=1 from the cycle after the last load beat; cyc_cnt+1 per cycle, saturating.
//     core_halted is ignored in the first RUN cycle (stale halt from the previous program).
//     halt: go to CHK_REQ. cyc_cnt==TIMEOUT-1 (TIMEOUT!=0): timeout=1, go to CHK_REQ.
//     halt and timeout in the same cycle: halt wins, timeout stays 0.
//     core_run drops to 0 on exit from RUN.
//   CHK_REQ: chk_ready=1. On beat: mem_re=1, mem_addr=chk_addr; latch chk_exp and chk_last; go to CHK_WAIT.
//   CHK_WAIT: chk_ready=0. Compare mem_rdata to the latched expected value; mismatch: err_cnt+1, saturating at all-ones.
//     Next state is DONE if the latched last flag is set, else CHK_REQ. Throughput: 1 check per 2 cycles.
//   DONE: done=1. pass = (err_cnt==0)&&!timeout&&!ld_ovf. Held until start or rst.
//   busy=1 in LOAD/RUN/CHK_*. mem_we and mem_re are never high together.
// CONFIGURATION
//   MISMATCH_LOG_EN defined: adds outputs bad_addr[ADDR_W], bad_act[DATA_W], bad_exp[DATA_W].
//     These capture the FIRST mismatch only, hold until start or rst, and reset to 0.
//   MISMATCH_LOG_EN undefined: those ports and registers are absent; only err_cnt reports mismatches.
// TESTING
//   1 Load 8 words {28010078,0ce77800,20220000,0ce77800,2842002d,0ce77800,24220001,fc000000}.
//     Then load 112 words of 0, then word 120=85. Core halts. Check (121,130) -> done=1, pass=1, err_cnt=0.
//   2 Same image, check (121,131),(120,85) -> err_cnt=1, pass=0.
//     With MISMATCH_LOG_EN: bad_addr=121, bad_act=130, bad_exp=131.
//   3 TIMEOUT=20, core_halted tied 0 -> timeout=1 and cyc_cnt=20 on leaving RUN; core_run low next cycle; pass=0.
//   4 ADDR_W=3, 10-beat image -> words 0..7 written, 2 beats suppressed, ld_ovf=1, pass=0.
//   5 rst pulsed mid-LOAD (beat 3) -> next cycle IDLE, core_run=0, ld_ready=0, all counters 0.
//     Re-run of test 1 then passes.
//   6 Halt asserted on the same cycle cyc_cnt hits TIMEOUT-1 -> timeout=0; stalled ld_valid/chk_valid honoured (no lost beats).

Source files
------------

// File: rtl/mips32_prog_loader.sv
// Program loader / result checker for the pipelined MIPS32 core: load image, run to HLT or
// timeout, then verify {addr, expected} pairs. Define MISMATCH_LOG_EN for first-mismatch capture.
`timescale 1ns/1ps
module mips32_prog_loader #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned CYC_W   = 16,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned ERR_W   = 8
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              chk_valid,
  output logic              chk_ready,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] chk_exp,
  input  logic              chk_last,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_run,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              ld_ovf,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [CYC_W-1:0]  cyc_cnt
`ifdef MISMATCH_LOG_EN
  ,
  output logic [ADDR_W-1:0] bad_addr,
  output logic [DATA_W-1:0] bad_act,
  output logic [DATA_W-1:0] bad_exp
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CHK_REQ, CHK_WAIT, DONE} state_t;
  state_t state, state_nxt;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);

  logic [ADDR_W:0]   ld_ptr;
  logic              ld_ovf_q, timeout_q, last_q;
  logic [ERR_W-1:0]  err_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [DATA_W-1:0] exp_q;
  logic              ld_beat, chk_beat, start_ok, halt_hit, to_hit, mismatch;

  // cyc_q is cleared on start, so zero marks the first RUN cycle where halt may be stale
  always_comb begin
    ld_beat  = (state == LOAD) && ld_valid;
    chk_beat = (state == CHK_REQ) && chk_valid;
    start_ok = start && ((state == IDLE) || (state == DONE));
    halt_hit = (state == RUN) && core_halted && (cyc_q != '0);
    to_hit   = (state == RUN) && (TIMEOUT != 0) && (cyc_q == CYC_LAST);
    mismatch = (state == CHK_WAIT) && (mem_rdata != exp_q);
  end

  always_ff @(posedge clk1) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD:       if (ld_valid && ld_last) state_nxt = RUN;
      RUN:        if (halt_hit || to_hit) state_nxt = CHK_REQ;
      CHK_REQ:    if (chk_valid) state_nxt = CHK_WAIT;
      CHK_WAIT:   state_nxt = last_q ? DONE : CHK_REQ;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_ready  = (state == LOAD);
    chk_ready = (state == CHK_REQ);
    mem_we    = ld_beat && !ld_ptr[ADDR_W];
    mem_re    = chk_beat;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_we) begin
      mem_addr  = ld_ptr[ADDR_W-1:0];
      mem_wdata = ld_data;
    end else if (mem_re) begin
      mem_addr  = chk_addr;
    end
    core_run  = (state == RUN);
    busy      = (state == LOAD) || (state == RUN) || (state == CHK_REQ) || (state == CHK_WAIT);
    done      = (state == DONE);
    pass      = done && (err_q == '0) && !timeout_q && !ld_ovf_q;
    timeout   = timeout_q;
    ld_ovf    = ld_ovf_q;
    err_cnt   = err_q;
    cyc_cnt   = cyc_q;
  end

  always_ff @(posedge clk1) begin
    if (rst || start_ok) begin
      ld_ptr    <= '0;
      ld_ovf_q  <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      cyc_q     <= '0;
      exp_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      // ld_ptr parks at 2**ADDR_W so further beats keep flagging overflow
      if (ld_beat) begin
        if (ld_ptr[ADDR_W]) ld_ovf_q <= 1'b1;
        else                ld_ptr   <= ld_ptr + (ADDR_W+1)'(1);
      end
      if ((state == RUN) && (cyc_q != '1)) cyc_q <= cyc_q + CYC_W'(1);
      if (to_hit && !halt_hit) timeout_q <= 1'b1;
      if (chk_beat) begin
        exp_q  <= chk_exp;
        last_q <= chk_last;
      end
      if (mismatch && (err_q != '1)) err_q <= err_q + ERR_W'(1);
    end
  end

`ifdef MISMATCH_LOG_EN
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk1) begin
    if (rst || start_ok) begin
      addr_q   <= '0;
      bad_addr <= '0;
      bad_act  <= '0;
      bad_exp  <= '0;
    end else begin
      if (chk_beat) addr_q <= chk_addr;
      if (mismatch && (err_q == '0)) begin
        bad_addr <= addr_q;
        bad_act  <= mem_rdata;
        bad_exp  <= exp_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: scoreboarded memory writes/reads plus status checks for
// halt, mismatch, timeout, halt-vs-timeout, reset abort and load overflow.
`timescale 1ns/1ps
module tb_mips32_prog_loader;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic rst, start, ld_valid, ld_ready, ld_last, chk_valid, chk_ready, chk_last;
  logic [DW-1:0] ld_data, chk_exp, mem_wdata, mem_rdata;
  logic [AW-1:0] chk_addr, mem_addr;
  logic mem_we, mem_re, core_run, core_halted, busy, done, pass, timeout, ld_ovf;
  logic [7:0]  err_cnt;
  logic [15:0] cyc_cnt;
`ifdef MISMATCH_LOG_EN
  logic [AW-1:0] bad_addr;
  logic [DW-1:0] bad_act, bad_exp;
`endif

  logic s_start, s_ld_valid, s_ld_ready, s_ld_last, s_chk_valid, s_chk_ready, s_chk_last;
  logic [DW-1:0] s_ld_data, s_chk_exp, s_mem_wdata, s_mem_rdata;
  logic [2:0] s_chk_addr, s_mem_addr;
  logic s_mem_we, s_mem_re, s_core_run, s_core_halted, s_busy, s_done, s_pass, s_timeout, s_ld_ovf;
  logic [7:0]  s_err_cnt;
  logic [15:0] s_cyc_cnt;
`ifdef MISMATCH_LOG_EN
  logic [2:0] s_bad_addr;
  logic [DW-1:0] s_bad_act, s_bad_exp;
`endif

  mips32_prog_loader #(.DATA_W(32), .ADDR_W(10), .CYC_W(16), .TIMEOUT(20), .ERR_W(8)) dut (
    .clk1(clk1), .rst(rst), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_addr(chk_addr), .chk_exp(chk_exp), .chk_last(chk_last),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_run(core_run), .core_halted(core_halted), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .ld_ovf(ld_ovf), .err_cnt(err_cnt), .cyc_cnt(cyc_cnt)
`ifdef MISMATCH_LOG_EN
    , .bad_addr(bad_addr), .bad_act(bad_act), .bad_exp(bad_exp)
`endif
  );

  mips32_prog_loader #(.DATA_W(32), .ADDR_W(3), .CYC_W(16), .TIMEOUT(1000), .ERR_W(8)) u_small (
    .clk1(clk1), .rst(rst), .start(s_start),
    .ld_valid(s_ld_valid), .ld_ready(s_ld_ready), .ld_data(s_ld_data), .ld_last(s_ld_last),
    .chk_valid(s_chk_valid), .chk_ready(s_chk_ready), .chk_addr(s_chk_addr), .chk_exp(s_chk_exp),
    .chk_last(s_chk_last), .mem_we(s_mem_we), .mem_re(s_mem_re), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata), .core_run(s_core_run), .core_halted(s_core_halted),
    .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_timeout), .ld_ovf(s_ld_ovf),
    .err_cnt(s_err_cnt), .cyc_cnt(s_cyc_cnt)
`ifdef MISMATCH_LOG_EN
    , .bad_addr(s_bad_addr), .bad_act(s_bad_act), .bad_exp(s_bad_exp)
`endif
  );

  // Memory models: registered read data, plus a core-side write port for the main memory
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] smem [8];
  logic core_we;
  logic [AW-1:0] core_waddr;
  logic [DW-1:0] core_wdata;

  always @(posedge clk1) begin
    if (mem_we)  mem[mem_addr] <= mem_wdata;
    if (core_we) mem[core_waddr] <= core_wdata;
    if (mem_re)  mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk1) begin
    if (s_mem_we) smem[s_mem_addr] <= s_mem_wdata;
    if (s_mem_re) s_mem_rdata <= smem[s_mem_addr];
  end

  logic [AW+DW-1:0] wq[$];
  logic [AW-1:0]    rq[$];
  logic [3+DW-1:0]  sq[$];
  logic [DW-1:0]    truth [1024];
  int checks = 0;
  int errors = 0;
  int bptr, exp_err;
  logic [AW-1:0] xb_addr;
  logic [DW-1:0] xb_act, xb_exp;

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic prep_load;
    bptr = 0; exp_err = 0;
    xb_addr = '0; xb_act = '0; xb_exp = '0;
    wq.delete(); rq.delete();
  endtask

  task automatic begin_load;
    prep_load();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL start_load ld_ready=%b required 1", ld_ready); end
  endtask

  task automatic send_ld(input logic [DW-1:0] d, input logic last);
    logic acc, want;
    logic [AW+DW-1:0] e;
    int n;
    want = (bptr < 1024);
    if (want) begin wq.push_back({AW'(bptr), d}); truth[bptr] = d; end
    bptr++;
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk1);
      acc = ld_ready;
      if (acc) begin
        checks++;
        if (mem_we !== want) begin errors++; $display("FAIL ld_we act=%b required %b", mem_we, want); end
        else if (want) begin
          e = wq.pop_front();
          checks++;
          if ({mem_addr, mem_wdata} !== e)
            begin errors++; $display("FAIL ld_write addr=%0d data=%h required addr=%0d data=%h", mem_addr, mem_wdata, e[AW+DW-1:DW], e[DW-1:0]); end
        end
      end else if (mem_we !== 1'b0) begin
        checks++; errors++; $display("FAIL ld_stall_we act=%b required 0", mem_we);
      end
      @(posedge clk1); #1; n++;
    end
    if (!acc) begin checks++; errors++; $display("FAIL ld_accept act=no_ready required ready"); end
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic send_chk(input logic [AW-1:0] a, input logic [DW-1:0] e, input logic last);
    logic acc;
    logic [AW-1:0] ea;
    int n;
    rq.push_back(a);
    if (truth[a] !== e) begin
      if (exp_err == 0) begin xb_addr = a; xb_act = truth[a]; xb_exp = e; end
      exp_err++;
    end
    chk_valid = 1'b1; chk_addr = a; chk_exp = e; chk_last = last;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk1);
      acc = chk_ready;
      if (acc) begin
        ea = rq.pop_front();
        checks++;
        if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ea)
          begin errors++; $display("FAIL chk_read re=%b we=%b addr=%0d required re=1 we=0 addr=%0d", mem_re, mem_we, mem_addr, ea); end
      end else if (mem_re !== 1'b0) begin
        checks++; errors++; $display("FAIL chk_stall_re act=%b required 0", mem_re);
      end
      @(posedge clk1); #1; n++;
    end
    if (!acc) begin checks++; errors++; $display("FAIL chk_accept act=no_ready required ready"); end
    chk_valid = 1'b0; chk_last = 1'b0;
  endtask

  // hc > 0: halt during RUN cycle hc (cycle 0 = first RUN cycle); hc <= 0: never halt
  task automatic run_core(input int hc, input logic stale, input logic [15:0] exp_cyc, input logic exp_to);
    int n;
    core_halted = stale;
    n = 0;
    while (core_run !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (core_run !== 1'b1) begin errors++; $display("FAIL run_start core_run=%b required 1", core_run); return; end
    if (hc > 0) begin
      for (int k = 0; k < hc; k++) begin tick(); core_halted = 1'b0; end
      core_halted = 1'b1;
      core_we = 1'b1; core_waddr = 10'd121; core_wdata = 32'd130; truth[121] = 32'd130;
    end else begin
      tick(); core_halted = 1'b0;
    end
    n = 0;
    while (core_run === 1'b1 && n < 100) begin tick(); core_we = 1'b0; n++; end
    core_we = 1'b0;
    checks++;
    if (cyc_cnt !== exp_cyc) begin errors++; $display("FAIL run_cyc act=%0d required %0d", cyc_cnt, exp_cyc); end
    checks++;
    if (timeout !== exp_to) begin errors++; $display("FAIL run_timeout act=%b required %b", timeout, exp_to); end
    checks++;
    if (core_run !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL run_exit core_run=%b busy=%b required 0 1", core_run, busy); end
  endtask

  task automatic finish_check(input logic exp_to, input logic exp_ovf);
    logic exp_pass;
    int n;
    exp_pass = (exp_err == 0) && !exp_to && !exp_ovf;
    n = 0;
    while (done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done act=%b required 1", done); end
    checks++;
    if (pass !== exp_pass) begin errors++; $display("FAIL pass act=%b required %b", pass, exp_pass); end
    checks++;
    if (err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL err_cnt act=%0d required %0d", err_cnt, exp_err); end
    checks++;
    if (timeout !== exp_to || ld_ovf !== exp_ovf)
      begin errors++; $display("FAIL flags timeout=%b ld_ovf=%b required %b %b", timeout, ld_ovf, exp_to, exp_ovf); end
    checks++;
    if (busy !== 1'b0 || core_run !== 1'b0) begin errors++; $display("FAIL done_idle busy=%b core_run=%b required 0 0", busy, core_run); end
    checks++;
    if (wq.size() != 0 || rq.size() != 0)
      begin errors++; $display("FAIL scoreboard_left wq=%0d rq=%0d required 0 0", wq.size(), rq.size()); end
`ifdef MISMATCH_LOG_EN
    checks++;
    if ({bad_addr, bad_act, bad_exp} !== {xb_addr, xb_act, xb_exp})
      begin errors++; $display("FAIL bad_log act=%0d/%h/%h required %0d/%h/%h", bad_addr, bad_act, bad_exp, xb_addr, xb_act, xb_exp); end
`endif
  endtask

  task automatic load_image1;
    logic [DW-1:0] prog [8];
    prog = '{32'h28010078, 32'h0ce77800, 32'h20220000, 32'h0ce77800,
             32'h2842002d, 32'h0ce77800, 32'h24220001, 32'hfc000000};
    for (int i = 0; i < 8; i++) send_ld(prog[i], 1'b0);
    for (int i = 0; i < 112; i++) send_ld('0, 1'b0);
    send_ld(32'd85, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1; repeat (3) tick(); rst = 1'b0;
    checks++;
    if ({busy, done, pass, timeout, ld_ovf, ld_ready, chk_ready, core_run, mem_we, mem_re} !== 10'b0)
      begin errors++; $display("FAIL reset_flags act=%b required 0", {busy, done, pass, timeout, ld_ovf, ld_ready, chk_ready, core_run, mem_we, mem_re}); end
    checks++;
    if (err_cnt !== 8'd0 || cyc_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt err=%0d cyc=%0d required 0 0", err_cnt, cyc_cnt); end
    checks++;
    if ({s_busy, s_done, s_pass, s_ld_ovf, s_core_run, s_mem_we} !== 6'b0)
      begin errors++; $display("FAIL reset_small act=%b required 0", {s_busy, s_done, s_pass, s_ld_ovf, s_core_run, s_mem_we}); end
  endtask

  task automatic test_halt_pass;
    begin_load();
    load_image1();
    run_core(5, 1'b1, 16'd6, 1'b0);
    send_chk(10'd121, 32'd130, 1'b1);
    finish_check(1'b0, 1'b0);
  endtask

  task automatic test_mismatch;
    begin_load();
    load_image1();
    run_core(5, 1'b1, 16'd6, 1'b0);
    send_chk(10'd121, 32'd131, 1'b0);
    send_chk(10'd120, 32'd85, 1'b1);
    finish_check(1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    begin_load();
    send_ld(32'h11, 1'b0); send_ld(32'h22, 1'b0); send_ld(32'h33, 1'b0); send_ld(32'h44, 1'b1);
    run_core(-1, 1'b0, 16'd20, 1'b1);
    send_chk(10'd2, 32'h33, 1'b1);
    finish_check(1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    prep_load();
    fork
      send_ld(32'ha0, 1'b0);
      begin tick(); start = 1'b1; tick(); start = 1'b0; end
    join
    send_ld(32'ha1, 1'b0);
    send_ld(32'ha2, 1'b1);
    fork
      run_core(19, 1'b0, 16'd20, 1'b0);
      begin
        send_chk(10'd0, 32'ha0, 1'b0);
        send_chk(10'd1, 32'ha1, 1'b0);
        send_chk(10'd2, 32'ha2, 1'b1);
      end
      begin repeat (5) tick(); start = 1'b1; tick(); start = 1'b0; end
    join
    finish_check(1'b0, 1'b0);
  endtask

  task automatic test_reset_abort;
    begin_load();
    send_ld(32'h1, 1'b0); send_ld(32'h2, 1'b0); send_ld(32'h3, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({busy, core_run, ld_ready, done, pass, timeout, ld_ovf, mem_we} !== 8'b0)
      begin errors++; $display("FAIL abort_flags act=%b required 0", {busy, core_run, ld_ready, done, pass, timeout, ld_ovf, mem_we}); end
    checks++;
    if (err_cnt !== 8'd0 || cyc_cnt !== 16'd0) begin errors++; $display("FAIL abort_cnt err=%0d cyc=%0d required 0 0", err_cnt, cyc_cnt); end
    test_halt_pass();
  endtask

  task automatic test_overflow;
    logic acc;
    logic [3+DW-1:0] e;
    int n;
    sq.delete();
    s_start = 1'b1; tick(); s_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) sq.push_back({3'(i), 32'h100 + i});
      s_ld_valid = 1'b1; s_ld_data = 32'h100 + i; s_ld_last = (i == 9);
      acc = 1'b0; n = 0;
      while (!acc && n < 20) begin
        @(negedge clk1);
        acc = s_ld_ready;
        if (acc) begin
          checks++;
          if (s_mem_we !== (i < 8)) begin errors++; $display("FAIL ovf_we beat=%0d act=%b required %b", i, s_mem_we, (i < 8)); end
          else if (i < 8) begin
            e = sq.pop_front();
            checks++;
            if ({s_mem_addr, s_mem_wdata} !== e)
              begin errors++; $display("FAIL ovf_write addr=%0d data=%h required addr=%0d data=%h", s_mem_addr, s_mem_wdata, e[DW+2:DW], e[DW-1:0]); end
          end
        end
        @(posedge clk1); #1; n++;
      end
      if (!acc) begin checks++; errors++; $display("FAIL ovf_accept beat=%0d act=no_ready required ready", i); end
    end
    s_ld_valid = 1'b0; s_ld_last = 1'b0;
    n = 0;
    while (s_done !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if ({s_done, s_ld_ovf, s_pass, s_timeout} !== 4'b1100)
      begin errors++; $display("FAIL ovf_status done/ovf/pass/to=%b required 1100", {s_done, s_ld_ovf, s_pass, s_timeout}); end
    checks++;
    if (s_err_cnt !== 8'd0 || sq.size() != 0) begin errors++; $display("FAIL ovf_err err=%0d left=%0d required 0 0", s_err_cnt, sq.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (smem[i] !== 32'h100 + i) begin errors++; $display("FAIL ovf_mem word=%0d act=%h required %h", i, smem[i], 32'h100 + i); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    chk_valid = 1'b0; chk_addr = '0; chk_exp = '0; chk_last = 1'b0; core_halted = 1'b0;
    core_we = 1'b0; core_waddr = '0; core_wdata = '0;
    s_start = 1'b0; s_ld_valid = 1'b0; s_ld_data = '0; s_ld_last = 1'b0;
    s_chk_valid = 1'b1; s_chk_addr = 3'd0; s_chk_exp = 32'h100; s_chk_last = 1'b1; s_core_halted = 1'b1;
    test_reset();
    test_halt_pass();
    test_mismatch();
    test_timeout();
    test_back_to_back();
    test_reset_abort();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
